// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, read-master state type and
// the response-to-error mapping used when capturing RRESP.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } rd_state_e;

  function automatic logic resp_is_err(input logic [1:0] rresp);
    return (rresp == RESP_SLVERR) || (rresp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4_lite_timeout_ctr.sv
// Per-phase cycle counter for the AXI4-Lite read master; expired_o flags the
// last permitted cycle of a phase (count == TIMEOUT_CYCLES-1).
module axi4_lite_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi4_lite_read_master.sv
// Single-outstanding AXI4-Lite read initiator. Define AXI4_LITE_RD_TIMEOUT_EN
// to abort an AR or R phase after TIMEOUT_CYCLES cycles without a handshake.
module axi4_lite_read_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  resp_timeout,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_param_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  rd_state_e             state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  timeout_q;
  logic                  timeout_hit;

`ifdef AXI4_LITE_RD_TIMEOUT_EN
  logic in_phase;
  logic phase_clear;

  assign in_phase    = (state_q == ST_ADDR) || (state_q == ST_DATA);
  // Clearing outside a phase and on the AR handshake gives count 0 in the first cycle of each phase.
  assign phase_clear = !in_phase || ((state_q == ST_ADDR) && M_AXI_ARREADY);

  axi4_lite_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (phase_clear),
    .enable_i (in_phase),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI_ARREADY) begin
            state_q <= ST_DATA;
          end else if (timeout_hit) begin
            data_q    <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_DATA: begin
          if (M_AXI_RVALID) begin
            data_q    <= M_AXI_RDATA;
            err_q     <= resp_is_err(M_AXI_RRESP);
            timeout_q <= 1'b0;
            state_q   <= ST_RESP;
          end else if (timeout_hit) begin
            data_q    <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign M_AXI_ARVALID = (state_q == ST_ADDR);
  assign M_AXI_RREADY  = (state_q == ST_DATA);
  assign resp_valid    = (state_q == ST_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign resp_data     = data_q;
  assign resp_err      = err_q;
  assign resp_timeout  = timeout_q;

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// Self-checking bench for axi4_lite_read_master: a behavioural AXI slave with
// randomized delays and an expected-result model derived from read latency rules.
module tb_axi4_lite_read_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        resp_timeout;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_lite_read_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .resp_timeout (resp_timeout),
    .M_AXI_ARADDR (M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA  (M_AXI_RDATA),
    .M_AXI_RRESP  (M_AXI_RRESP),
    .M_AXI_RVALID (M_AXI_RVALID),
    .M_AXI_RREADY (M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays the slave; only records what it observes.
  task automatic run_read(input logic [31:0] addr, input int ar_d, input int r_d,
                          input logic [31:0] data, input logic [1:0] rresp, input int bound,
                          output int arv_n, output int rr_n, output int resp_cyc,
                          output int pulses, output logic [31:0] rd, output logic re,
                          output logic rt, output bit addr_ok, output bit busy_ok);
    arv_n = 0; rr_n = 0; resp_cyc = -1; pulses = 0;
    rd = '0; re = 1'b0; rt = 1'b0; addr_ok = 1'b1; busy_ok = 1'b1;
    req_addr  = addr;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID  = 1'b0;
      if (M_AXI_ARVALID) begin
        arv_n++;
        if (M_AXI_ARADDR !== addr) addr_ok = 1'b0;
        M_AXI_ARREADY = (arv_n == ar_d + 1);
        M_AXI_RVALID  = 1'($urandom_range(0, 1));
        M_AXI_RDATA   = $urandom;
        M_AXI_RRESP   = 2'($urandom_range(0, 3));
      end
      if (M_AXI_RREADY) begin
        rr_n++;
        if (rr_n == r_d + 1) begin
          M_AXI_RVALID = 1'b1;
          M_AXI_RDATA  = data;
          M_AXI_RRESP  = rresp;
        end
      end
      if (M_AXI_ARVALID && M_AXI_RREADY) busy_ok = 1'b0;
      if ((M_AXI_ARVALID || M_AXI_RREADY || resp_valid) && req_ready) busy_ok = 1'b0;
      if (resp_valid) begin
        pulses++;
        if (resp_cyc < 0) begin
          resp_cyc = cyc; rd = resp_data; re = resp_err; rt = resp_timeout;
        end
      end
      if (pulses > 0 && req_ready) break;
      tick();
    end
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if ({req_ready, M_AXI_ARVALID, M_AXI_RREADY, resp_valid, resp_err, resp_timeout} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 100000",
               {req_ready, M_AXI_ARVALID, M_AXI_RREADY, resp_valid, resp_err, resp_timeout});
    end
    n_checks++;
    if ({resp_data, M_AXI_ARADDR} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: resp_data %h araddr %h expected 0", resp_data, M_AXI_ARADDR);
    end
    rst = 1'b0;
    M_AXI_ARREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({req_ready, M_AXI_ARVALID} !== 2'b10) begin
        n_fail++;
        $display("FAIL idle_arready: ready/arvalid got %b expected 10", {req_ready, M_AXI_ARVALID});
      end
    end
    M_AXI_ARREADY = 1'b0;
  endtask

  task automatic test_basic();
    int arv, rr, rc, p; logic [31:0] rd; logic re, rt; bit aok, bok;
    run_read(32'h0000_0010, 0, 0, 32'hDEAD_BEEF, 2'b00, 20, arv, rr, rc, p, rd, re, rt, aok, bok);
    n_checks++;
    if (rc !== 3 || p !== 1) begin
      n_fail++; $display("FAIL basic_latency: resp cycle %0d pulses %0d expected 3 and 1", rc, p);
    end
    n_checks++;
    if ({rd, re, rt} !== {32'hDEAD_BEEF, 2'b00}) begin
      n_fail++; $display("FAIL basic_data: got %h/%b/%b expected deadbeef/0/0", rd, re, rt);
    end
    n_checks++;
    if (!aok || arv !== 1 || !bok) begin
      n_fail++; $display("FAIL basic_ar: addr_ok %0d arvalid cycles %0d busy_ok %0d expected 1/1/1", aok, arv, bok);
    end
  endtask

  task automatic test_backpressure();
    int arv, rr, rc, p; logic [31:0] rd; logic re, rt; bit aok, bok;
    run_read(32'h0000_1234, 5, 3, 32'hCAFE_F00D, 2'b00, 40, arv, rr, rc, p, rd, re, rt, aok, bok);
    n_checks++;
    if (arv !== 6 || !aok) begin
      n_fail++; $display("FAIL bp_arvalid: cycles %0d stable %0d expected 6/1", arv, aok);
    end
    n_checks++;
    if (rr !== 4) begin
      n_fail++; $display("FAIL bp_rready: cycles %0d expected 4", rr);
    end
    n_checks++;
    if (p !== 1 || rc !== 11 || rd !== 32'hCAFE_F00D || !bok) begin
      n_fail++; $display("FAIL bp_resp: pulses %0d cycle %0d data %h busy_ok %0d expected 1/11/cafef00d/1", p, rc, rd, bok);
    end
  endtask

  task automatic test_errors();
    logic [1:0]  codes [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [31:0] datas [4] = '{32'h1234_5678, 32'h8765_4321, 32'h0BAD_F00D, 32'h5555_AAAA};
    int arv, rr, rc, p; logic [31:0] rd; logic re, rt; bit aok, bok;
    for (int i = 0; i < 4; i++) begin
      run_read(32'h100 + 32'(i * 4), 1, 1, datas[i], codes[i], 30, arv, rr, rc, p, rd, re, rt, aok, bok);
      n_checks++;
      if ({rd, re, rt} !== {datas[i], codes[i] >= 2'd2, 1'b0} || p !== 1) begin
        n_fail++;
        $display("FAIL err_resp rresp=%b: got %h/%b/%b pulses %0d expected %h/%b/0/1",
                 codes[i], rd, re, rt, p, datas[i], codes[i] >= 2'd2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    M_AXI_ARREADY = 1'b1;
    M_AXI_RVALID  = 1'b1;
    M_AXI_RRESP   = 2'b00;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    tick();
    req_addr  = 32'h8;
    for (int c = 1; c <= 8; c++) begin
      exp_addr = (c < 5) ? 32'h4 : 32'h8;
      n_checks++;
      if ({req_ready, M_AXI_ARVALID, M_AXI_RREADY, resp_valid} !==
          {c % 4 == 0, c % 4 == 1, c % 4 == 2, c % 4 == 3}) begin
        n_fail++;
        $display("FAIL b2b_ctrl cycle %0d: got %b expected %b", c,
                 {req_ready, M_AXI_ARVALID, M_AXI_RREADY, resp_valid},
                 {c % 4 == 0, c % 4 == 1, c % 4 == 2, c % 4 == 3});
      end
      if (c % 4 == 1) begin
        n_checks++;
        if (M_AXI_ARADDR !== exp_addr) begin
          n_fail++; $display("FAIL b2b_addr cycle %0d: got %h expected %h", c, M_AXI_ARADDR, exp_addr);
        end
      end
      if (c % 4 == 3) begin
        n_checks++;
        if (resp_data !== 32'hA000_0000 + 32'(c - 1)) begin
          n_fail++; $display("FAIL b2b_data cycle %0d: got %h expected %h", c, resp_data, 32'hA000_0000 + 32'(c - 1));
        end
      end
      if (c == 5) req_valid = 1'b0;
      M_AXI_RDATA = 32'hA000_0000 + 32'(c);
      tick();
    end
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    int arv, rr, rc, p; logic [31:0] rd; logic re, rt; bit aok, bok;
    req_addr = 32'h40; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0;
    n_checks++;
    if (M_AXI_RREADY !== 1'b1) begin
      n_fail++; $display("FAIL arst_setup: rready got %b expected 1", M_AXI_RREADY);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({M_AXI_ARVALID, M_AXI_RREADY, resp_valid, req_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL arst_immediate: got %b expected 0001",
                         {M_AXI_ARVALID, M_AXI_RREADY, resp_valid, req_ready});
    end
    #2 rst = 1'b0;
    M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hBAD0_BAD0; M_AXI_RRESP = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid || M_AXI_ARVALID || M_AXI_RREADY) seen = 1'b1;
    end
    M_AXI_RVALID = 1'b0;
    n_checks++;
    if (seen !== 1'b0 || resp_data !== 32'h0) begin
      n_fail++; $display("FAIL arst_discard: activity %0d resp_data %h expected 0/0", seen, resp_data);
    end
    run_read(32'h44, 2, 1, 32'h0102_0304, 2'b00, 30, arv, rr, rc, p, rd, re, rt, aok, bok);
    n_checks++;
    if (rc !== 6 || p !== 1 || rd !== 32'h0102_0304 || re !== 1'b0) begin
      n_fail++; $display("FAIL arst_recover: cycle %0d pulses %0d data %h err %b expected 6/1/01020304/0", rc, p, rd, re);
    end
  endtask

  task automatic test_random();
    int arv, rr, rc, p; logic [31:0] rd; logic re, rt; bit aok, bok;
    logic [31:0] a, d; logic [1:0] r; int ad, dd;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; d = $urandom; r = 2'($urandom_range(0, 3));
      ad = $urandom_range(0, 4); dd = $urandom_range(0, 4);
      run_read(a, ad, dd, d, r, 40, arv, rr, rc, p, rd, re, rt, aok, bok);
      n_checks++;
      if (rc !== ad + dd + 3 || p !== 1 || arv !== ad + 1 || rr !== dd + 1 ||
          rd !== d || re !== (r == 2'b10 || r == 2'b11) || rt !== 1'b0 || !aok || !bok) begin
        n_fail++;
        $display("FAIL rand_%0d: cyc %0d/%0d pulses %0d arv %0d/%0d rr %0d/%0d data %h/%h err %b rt %b aok %0d bok %0d",
                 i, rc, ad + dd + 3, p, arv, ad + 1, rr, dd + 1, rd, d, re, rt, aok, bok);
      end
    end
  endtask

`ifdef AXI4_LITE_RD_TIMEOUT_EN
  task automatic test_timeout();
    int arv, rr, rc, p; logic [31:0] rd; logic re, rt; bit aok, bok;
    run_read(32'h200, 1000, 0, 32'h1111_1111, 2'b00, 60, arv, rr, rc, p, rd, re, rt, aok, bok);
    n_checks++;
    if (arv !== TO || rc !== TO + 1 || p !== 1 || {rd, re, rt} !== {32'h0, 2'b11}) begin
      n_fail++; $display("FAIL to_addr: arv %0d cyc %0d pulses %0d data %h err %b rt %b expected %0d/%0d/1/0/1/1",
                         arv, rc, p, rd, re, rt, TO, TO + 1);
    end
    run_read(32'h204, TO - 1, 0, 32'h2222_2222, 2'b00, 60, arv, rr, rc, p, rd, re, rt, aok, bok);
    n_checks++;
    if (arv !== TO || rc !== TO + 2 || {rd, re, rt} !== {32'h2222_2222, 2'b00}) begin
      n_fail++; $display("FAIL to_addr_last: arv %0d cyc %0d data %h err %b rt %b expected %0d/%0d/22222222/0/0",
                         arv, rc, rd, re, rt, TO, TO + 2);
    end
    run_read(32'h208, 0, 1000, 32'h3333_3333, 2'b00, 60, arv, rr, rc, p, rd, re, rt, aok, bok);
    n_checks++;
    if (rr !== TO || rc !== TO + 2 || p !== 1 || {rd, re, rt} !== {32'h0, 2'b11}) begin
      n_fail++; $display("FAIL to_data: rr %0d cyc %0d pulses %0d data %h err %b rt %b expected %0d/%0d/1/0/1/1",
                         rr, rc, p, rd, re, rt, TO, TO + 2);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_valid = 1'b0; req_addr = '0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef AXI4_LITE_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
